// File: rtl/bbf_real_alu_pipe.sv
// Multi-lane IEEE-754 double ALU with a configurable-latency valid/ready pipe.
// Simulation model: lane math goes through $bitstoreal/$realtobits.

package bbf_real_alu_pkg;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;
  localparam logic [63:0] PINF = 64'h7FF0000000000000;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL  = 4'd2,  OP_DIV   = 4'd3;
  localparam logic [3:0] OP_MIN = 4'd4,  OP_MAX = 4'd5,  OP_SQRT = 4'd6,  OP_FRINT = 4'd7;
  localparam logic [3:0] OP_TOI = 4'd8,  OP_LT  = 4'd9,  OP_EQ   = 4'd10;

  // flag bit positions: {invalid, div_zero, int_ovf, bad_op}
  localparam int F_INV = 3, F_DZ = 2, F_OVF = 1, F_BOP = 0;

  typedef struct packed {
    logic [63:0] data;
    logic        cmp;
    logic [3:0]  flg;
  } lane_rsp_t;

  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  function automatic logic is_zero(input logic [63:0] x);
    return x[62:0] == 63'd0;
  endfunction
endpackage

// One lane: purely combinational result for a single 64-bit operand pair.
module bbf_real_alu_lane
  import bbf_real_alu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output lane_rsp_t   rsp
);
  real ra, rb, rr, rt;
  logic signed [63:0] ia;
  logic na, nb;

  // Decode opcode and produce data/cmp/flags; special cases are caught on raw bits.
  always_comb begin
    rsp = '0;
    ra  = $bitstoreal(a);
    rb  = $bitstoreal(b);
    rr  = 0.0;
    rt  = 0.0;
    ia  = a;
    na  = is_nan(a);
    nb  = is_nan(b);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
        if (na || nb) begin
          rsp.data = QNAN; rsp.flg[F_INV] = 1'b1;
        end else if (op == OP_DIV && is_zero(b)) begin
          if (is_zero(a)) begin
            rsp.data = QNAN; rsp.flg[F_INV] = 1'b1;
          end else begin
            rsp.data = PINF | {a[63] ^ b[63], 63'd0};
            rsp.flg[F_DZ] = 1'b1;
          end
        end else begin
          if      (op == OP_ADD) rr = ra + rb;
          else if (op == OP_SUB) rr = ra - rb;
          else if (op == OP_MUL) rr = ra * rb;
          else                   rr = ra / rb;
          rsp.data = $realtobits(rr);
          // inf-inf, 0*inf and friends: canonicalise whatever NaN the simulator made
          if (is_nan(rsp.data)) begin
            rsp.data = QNAN; rsp.flg[F_INV] = 1'b1;
          end
        end
      end
      OP_MIN, OP_MAX: begin
        if (na || nb) begin
          rsp.data = QNAN; rsp.flg[F_INV] = 1'b1;
        end else if (op == OP_MIN) begin
          rsp.data = (rb < ra) ? b : a;  // ties (incl. -0/+0) keep A
        end else begin
          rsp.data = (rb > ra) ? b : a;
        end
      end
      OP_SQRT: begin
        if (na) begin
          rsp.data = QNAN; rsp.flg[F_INV] = 1'b1;
        end else if (is_zero(a)) begin
          rsp.data = a;                  // sqrt(-0) = -0
        end else if (a[63]) begin
          rsp.data = QNAN; rsp.flg[F_INV] = 1'b1;
        end else begin
          rsp.data = $realtobits($sqrt(ra));
        end
      end
      OP_FRINT: rsp.data = $realtobits(real'(ia));
      OP_TOI: begin
        if (na) begin
          rsp.flg[F_INV] = 1'b1;
        end else if (ra >= 9223372036854775808.0) begin
          rsp.data = 64'h7FFFFFFFFFFFFFFF; rsp.flg[F_OVF] = 1'b1;
        end else if (ra < -9223372036854775808.0) begin
          rsp.data = 64'h8000000000000000; rsp.flg[F_OVF] = 1'b1;
        end else begin
          // truncate first so the integer conversion is exact
          rt = (ra < 0.0) ? -$floor(-ra) : $floor(ra);
          rsp.data = longint'(rt);
        end
      end
      OP_LT, OP_EQ: begin
        if (na || nb) rsp.flg[F_INV] = 1'b1;
        else if (op == OP_LT) rsp.cmp = (ra < rb);
        else                  rsp.cmp = (ra == rb);
      end
      default: rsp.flg[F_BOP] = 1'b1;
    endcase
  end
endmodule

// Top: shared opcode across lanes, LATENCY register stages, stall-all flow control.
module bbf_real_alu_pipe
  import bbf_real_alu_pkg::*;
#(
  parameter int LANES   = 1,
  parameter int LATENCY = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [64*LANES-1:0]   in_a,
  input  logic [64*LANES-1:0]   in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_cmp,
  output logic [3:0]            flags,
  input  logic                  flags_clr
);
  typedef struct packed {
    logic [LANES-1:0][63:0] data;
    logic [LANES-1:0]       cmp;
    logic [3:0]             flg;
  } stg_t;

  logic [LANES-1:0][63:0] a_l, b_l;
  lane_rsp_t [LANES-1:0]  rsp;
  stg_t                   nxt;
  stg_t                   stg [1:LATENCY];
  logic [LATENCY:1]       vld_pipe;
  logic                   run_q, acc, stall;
  logic [3:0]             ev;

  assign a_l = in_a;
  assign b_l = in_b;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bbf_real_alu_lane u_lane (.op(in_op), .a(a_l[i]), .b(b_l[i]), .rsp(rsp[i]));
  end

  assign stall     = vld_pipe[LATENCY] && !out_ready;
  assign in_ready  = run_q && !stall;  // registered run bit keeps ready low through reset
  assign acc       = in_valid && in_ready;
  assign out_valid = vld_pipe[LATENCY];
  assign out_data  = stg[LATENCY].data;
  assign out_cmp   = stg[LATENCY].cmp;
  assign ev        = (out_valid && out_ready) ? stg[LATENCY].flg : 4'd0;

  // Gather lane results into the stage-1 word; flags OR across lanes.
  always_comb begin
    nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      nxt.data[i] = rsp[i].data;
      nxt.cmp[i]  = rsp[i].cmp;
      nxt.flg     = nxt.flg | rsp[i].flg;
    end
  end

  // Pipeline advance: whole pipe holds on stall; bubbles load as zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      vld_pipe <= '0;
      for (int k = 1; k <= LATENCY; k++) stg[k] <= '0;
    end else begin
      run_q <= 1'b1;
      if (!stall) begin
        vld_pipe[1] <= acc;
        stg[1]      <= acc ? nxt : '0;
        for (int k = 2; k <= LATENCY; k++) begin
          vld_pipe[k] <= vld_pipe[k-1];
          stg[k]      <= stg[k-1];
        end
      end
    end
  end

  // Sticky flags set on beat departure; a same-cycle event beats the clear.
  always_ff @(posedge clock) begin
    if (!reset_n)       flags <= 4'd0;
    else if (flags_clr) flags <= ev;
    else                flags <= flags | ev;
  end
endmodule
